// File: rtl/gcd_fraction_reducer_if.sv
// Handshake bundle between the GCD stage, the fraction reducer and its consumer.
// The master side supplies operands and accepts results; the slave side is the reducer.
`timescale 1ns/1ps
interface gcd_fraction_reducer_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] den;
    logic [WIDTH-1:0] gcd;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] num_red;
    logic [WIDTH-1:0] den_red;
    logic [1:0]       status;

    modport master (
        output in_valid, num, den, gcd, out_ready,
        input  in_ready, out_valid, num_red, den_red, status
    );

    modport slave (
        input  in_valid, num, den, gcd, out_ready,
        output in_ready, out_valid, num_red, den_red, status
    );
endinterface

// File: rtl/gcd_fraction_reducer.sv
// Fraction reducer: divides num and den by their GCD with one shared restoring
// divider (one quotient bit per clock, numerator first, then denominator).
// A zero GCD skips division and reports status[0]; any nonzero remainder sets status[1].
`timescale 1ns/1ps
module gcd_fraction_reducer #(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    gcd_fraction_reducer_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV_N = 2'd1,
        DIV_D = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem;        // one extra bit so the shifted remainder cannot overflow
    logic [WIDTH-1:0] dividend;   // shifted left each step; MSB feeds the remainder
    logic [WIDTH-1:0] den_hold;   // denominator waits here while the numerator divides
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quot;
    logic             zero_gcd;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   step_rem;
    logic             step_qbit;
    logic [WIDTH-1:0] step_quot;
    logic             last_step;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted = {rem[WIDTH-1:0], dividend[WIDTH-1]};
        if (shifted >= {1'b0, divisor}) begin
            step_rem  = shifted - {1'b0, divisor};
            step_qbit = 1'b1;
        end else begin
            step_rem  = shifted;
            step_qbit = 1'b0;
        end
        step_quot = {quot[WIDTH-2:0], step_qbit};
        last_step = (count == CW'(WIDTH - 1));
    end

    // Control FSM, divider datapath and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.num_red   <= {WIDTH{1'b0}};
            bus.den_red   <= {WIDTH{1'b0}};
            bus.status    <= 2'b00;
            count         <= {CW{1'b0}};
            rem           <= {(WIDTH+1){1'b0}};
            dividend      <= {WIDTH{1'b0}};
            den_hold      <= {WIDTH{1'b0}};
            divisor       <= {WIDTH{1'b0}};
            quot          <= {WIDTH{1'b0}};
            zero_gcd      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bus.in_ready <= 1'b0;
                        dividend     <= bus.num;
                        den_hold     <= bus.den;
                        divisor      <= bus.gcd;
                        zero_gcd     <= (bus.gcd == {WIDTH{1'b0}});
                        count        <= {CW{1'b0}};
                        rem          <= {(WIDTH+1){1'b0}};
                        quot         <= {WIDTH{1'b0}};
                        bus.status   <= 2'b00;
                        state        <= DIV_N;
                    end
                end
                DIV_N: begin
                    if (zero_gcd) begin
                        // Zero divisor: no division, result is 0/0 one edge after accept.
                        bus.num_red   <= {WIDTH{1'b0}};
                        bus.den_red   <= {WIDTH{1'b0}};
                        bus.status    <= 2'b01;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else if (last_step) begin
                        bus.num_red   <= step_quot;
                        bus.status[1] <= |step_rem;
                        dividend      <= den_hold;
                        rem           <= {(WIDTH+1){1'b0}};
                        quot          <= {WIDTH{1'b0}};
                        count         <= {CW{1'b0}};
                        state         <= DIV_D;
                    end else begin
                        rem      <= step_rem;
                        quot     <= step_quot;
                        dividend <= {dividend[WIDTH-2:0], 1'b0};
                        count    <= count + CW'(1);
                    end
                end
                DIV_D: begin
                    if (last_step) begin
                        bus.den_red   <= step_quot;
                        bus.status[1] <= bus.status[1] | (|step_rem);
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        rem      <= step_rem;
                        quot     <= step_quot;
                        dividend <= {dividend[WIDTH-2:0], 1'b0};
                        count    <= count + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_fraction_reducer.sv
// Directed bench for gcd_fraction_reducer: an arithmetic reference model (plain / and %)
// predicts handshakes and results every cycle; literal expectations pin the model.
`timescale 1ns/1ps
module tb_gcd_fraction_reducer;
    logic clk = 1'b0;
    logic rst;

    gcd_fraction_reducer_if #(.WIDTH(32)) bus ();

    gcd_fraction_reducer #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic        checking = 1'b0;
    logic        busy     = 1'b0;
    longint      cyc      = 0;
    longint      done_at  = 0;
    logic [31:0] exp_n = 32'd0, exp_d = 32'd0;
    logic [1:0]  exp_s = 2'b00;
    logic [31:0] last_n = 32'd0, last_d = 32'd0;
    logic [1:0]  last_s = 2'b00;
    longint      acc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Model: one fraction in flight, result appears a fixed latency after acceptance.
    always @(posedge clk) begin
        if (!rst) begin
            checking <= 1'b1;
            busy     <= 1'b0;
            last_n   <= 32'd0;
            last_d   <= 32'd0;
            last_s   <= 2'b00;
        end else if (busy) begin
            if (cyc >= done_at && bus.out_ready) begin
                busy   <= 1'b0;
                last_n <= exp_n;
                last_d <= exp_d;
                last_s <= exp_s;
            end
        end else if (bus.in_valid) begin
            busy <= 1'b1;
            if (bus.gcd == 32'd0) begin
                exp_n   <= 32'd0;
                exp_d   <= 32'd0;
                exp_s   <= 2'b01;
                done_at <= cyc + 64'sd2;
            end else begin
                exp_n   <= bus.num / bus.gcd;
                exp_d   <= bus.den / bus.gcd;
                exp_s   <= {((bus.num % bus.gcd) != 32'd0) || ((bus.den % bus.gcd) != 32'd0), 1'b0};
                done_at <= cyc + 64'sd65;
            end
        end
        cyc <= cyc + 64'sd1;
    end

    // Compare DUT outputs with the model on every falling edge.
    always @(negedge clk) begin
        if (checking) begin
            chk("in_ready", {63'd0, bus.in_ready}, {63'd0, !busy});
            chk("out_valid", {63'd0, bus.out_valid}, {63'd0, busy && (cyc >= done_at)});
            if (!busy) begin
                chk("num_red_held", {32'd0, bus.num_red}, {32'd0, last_n});
                chk("den_red_held", {32'd0, bus.den_red}, {32'd0, last_d});
                chk("status_held", {62'd0, bus.status}, {62'd0, last_s});
            end else if (cyc >= done_at) begin
                chk("num_red", {32'd0, bus.num_red}, {32'd0, exp_n});
                chk("den_red", {32'd0, bus.den_red}, {32'd0, exp_d});
                chk("status", {62'd0, bus.status}, {62'd0, exp_s});
            end
        end
    end

    task automatic send(input logic [31:0] n, input logic [31:0] d, input logic [31:0] g);
        int k = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.num = n;
        bus.den = d;
        bus.gcd = g;
        while (!bus.in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            failures++;
            $display("FAIL accept_timeout actual=%0d required=<200", k);
        end
        @(posedge clk);
        #1;
        acc = cyc;
        bus.in_valid = 1'b0;
        // Operands must be ignored after the accept edge.
        bus.num = $urandom;
        bus.den = $urandom;
        bus.gcd = $urandom;
    endtask

    task automatic get_result(input string nm, input logic [31:0] n, input logic [31:0] d,
                              input logic [1:0] s, input int lat, input int hold);
        int k = 0;
        @(negedge clk);
        while (!bus.out_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d required=<300", nm, k);
        end
        chk({nm, "_latency"}, 64'(cyc - acc), 64'(lat));
        chk({nm, "_num"}, {32'd0, bus.num_red}, {32'd0, n});
        chk({nm, "_den"}, {32'd0, bus.den_red}, {32'd0, d});
        chk({nm, "_status"}, {62'd0, bus.status}, {62'd0, s});
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = (i < 3);
            bus.num = 32'd1;
            bus.den = 32'd1;
            bus.gcd = 32'd1;
            @(negedge clk);
            chk({nm, "_hold_valid"}, {63'd0, bus.out_valid}, 64'd1);
            chk({nm, "_hold_ready"}, {63'd0, bus.in_ready}, 64'd0);
            chk({nm, "_hold_num"}, {32'd0, bus.num_red}, {32'd0, n});
            chk({nm, "_hold_den"}, {32'd0, bus.den_red}, {32'd0, d});
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_ready_after"}, {63'd0, bus.in_ready}, 64'd1);
        chk({nm, "_valid_after"}, {63'd0, bus.out_valid}, 64'd0);
        chk({nm, "_num_kept"}, {32'd0, bus.num_red}, {32'd0, n});
    endtask

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.num = 32'd0;
        bus.den = 32'd0;
        bus.gcd = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_num_red", {32'd0, bus.num_red}, 64'd0);
        chk("rst_status", {62'd0, bus.status}, 64'd0);
        rst = 1'b1;

        send(32'd56, 32'd98, 32'd14);
        get_result("t1", 32'd4, 32'd7, 2'b00, 64, 0);

        send(32'd48, 32'd18, 32'd6);
        get_result("t2a", 32'd8, 32'd3, 2'b00, 64, 0);
        bus.out_ready = 1'b1;
        send(32'd101, 32'd103, 32'd1);
        get_result("t2b", 32'd101, 32'd103, 2'b00, 64, 0);

        send(32'd5, 32'd7, 32'd0);
        get_result("t3", 32'd0, 32'd0, 2'b01, 1, 0);

        send(32'd12, 32'd20, 32'd5);
        get_result("t4a", 32'd2, 32'd4, 2'b10, 64, 0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        get_result("t4b", 32'd1, 32'd1, 2'b00, 64, 0);

        send(32'd48, 32'd18, 32'd6);
        get_result("t5", 32'd8, 32'd3, 2'b00, 64, 10);

        send(32'd56, 32'd98, 32'd14);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.num = 32'd1;
        bus.den = 32'd1;
        bus.gcd = 32'd1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t6_num_red", {32'd0, bus.num_red}, 64'd0);
        chk("t6_den_red", {32'd0, bus.den_red}, 64'd0);
        chk("t6_status", {62'd0, bus.status}, 64'd0);
        chk("t6_in_ready", {63'd0, bus.in_ready}, 64'd1);
        repeat (70) @(negedge clk);
        send(32'd56, 32'd98, 32'd14);
        get_result("t6", 32'd4, 32'd7, 2'b00, 64, 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
